// File: rtl/servo_loop_sequencer_pkg.sv
// Shared types and defaults for the servo loop sequencer and its duty path.
package servo_loop_sequencer_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DUTY_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_ADC_REQ,
    ST_ADC_WAIT,
    ST_CALC,
    ST_CLAMP,
    ST_WAIT_PWM,
    ST_FAULT
  } state_t;

  // States in which a sample tick is legitimately consumed or ignored
  // (anywhere else a tick means the previous sample is still in flight).
  function automatic logic tick_slot(input state_t s);
    return (s == ST_IDLE) || (s == ST_WAIT_TICK) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/servo_loop_sequencer_duty_saturator.sv
// Combinational clamp of a signed controller output onto an unsigned duty range.
module duty_saturator
  import servo_loop_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DUTY_W = DUTY_W_DEF
) (
  input  logic [DATA_W-1:0] yk,
  output logic [DUTY_W-1:0] duty
);

  // Negative -> 0, above full scale -> all ones, otherwise pass low bits.
  always_comb begin
    duty = yk[DUTY_W-1:0];
    if (yk[DATA_W-1]) begin
      duty = '0;
    end else if (|yk[DATA_W-2:DUTY_W]) begin
      duty = '1;
    end
  end

endmodule

// File: rtl/servo_loop_sequencer.sv
// One servo sample per tick: ADC request/wait, IPD compute window, duty clamp,
// and duty commit at the PWM period boundary, with ADC timeout fault and
// sample-overrun counting.
module servo_loop_sequencer
  import servo_loop_sequencer_pkg::*;
#(
  parameter int unsigned       DATA_W      = DATA_W_DEF,
  parameter int unsigned       DUTY_W      = DUTY_W_DEF,
  parameter int unsigned       SAMPLE_DIV  = 50000,
  parameter int unsigned       ADC_TIMEOUT = 2000,
  parameter int unsigned       CALC_CYCLES = 4,
  parameter logic [DUTY_W-1:0] SAFE_DUTY   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] pot_latched,
  output logic              ctrl_en,
  input  logic [DATA_W-1:0] ctrl_yk,
  input  logic              pwm_period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_update,
  output logic              busy,
  output logic              fault,
  output logic [7:0]        overrun_cnt
);

  localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned TMO_W  = $clog2(ADC_TIMEOUT + 1);
  localparam int unsigned CALC_W = $clog2(CALC_CYCLES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ADC_TIMEOUT - 1);
  localparam logic [CALC_W-1:0] CALC_LAST = CALC_W'(CALC_CYCLES - 1);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [CALC_W-1:0]   calc_q, calc_d;
  logic [DATA_W-1:0]   pot_q, pot_d;
  logic [DATA_W-1:0]   yk_q, yk_d;
  logic [DUTY_W-1:0]   pending_q, pending_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic                dupd_q, dupd_d;
  logic [7:0]          ovr_q, ovr_d;
  logic                tick;
  logic [DUTY_W-1:0]   sat_duty;

  duty_saturator #(
    .DATA_W (DATA_W),
    .DUTY_W (DUTY_W)
  ) u_sat (
    .yk   (yk_q),
    .duty (sat_duty)
  );

  // Sample tick divider: runs only while enabled, pulses on the last count.
  always_comb begin
    div_d = '0;
    tick  = 1'b0;
    if (enable) begin
      if (div_q == DIV_LAST) begin
        tick = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; dropping enable aborts from anywhere.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_WAIT_TICK;
        ST_WAIT_TICK: if (tick) state_d = ST_ADC_REQ;
        ST_ADC_REQ:   state_d = ST_ADC_WAIT;
        ST_ADC_WAIT: begin
          if (adc_done) begin
            state_d = ST_CALC;
          end else if (tmo_q == TMO_LAST) begin
            state_d = ST_FAULT;
          end
        end
        ST_CALC:      if (calc_q == CALC_LAST) state_d = ST_CLAMP;
        ST_CLAMP:     state_d = ST_WAIT_PWM;
        ST_WAIT_PWM:  if (pwm_period_end) state_d = ST_WAIT_TICK;
        ST_FAULT:     state_d = ST_FAULT;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: counters, captures, duty commit, overrun count.
  always_comb begin
    tmo_d     = (state_q == ST_ADC_WAIT) ? tmo_q + 1'b1 : '0;
    calc_d    = (state_q == ST_CALC) ? calc_q + 1'b1 : '0;
    pot_d     = pot_q;
    yk_d      = yk_q;
    pending_d = pending_q;
    duty_d    = duty_q;
    dupd_d    = 1'b0;
    ovr_d     = ovr_q;

    if (enable && state_q == ST_ADC_WAIT && adc_done) begin
      pot_d = adc_data;
    end
    if (state_q == ST_CALC && calc_q == CALC_LAST) begin
      yk_d = ctrl_yk;
    end
    if (state_q == ST_CLAMP) begin
      pending_d = sat_duty;
    end

    // Safe duty is forced only on the edge that enters FAULT.
    if (enable && state_q == ST_WAIT_PWM && pwm_period_end) begin
      duty_d = pending_q;
      dupd_d = 1'b1;
    end else if (state_q != ST_FAULT && state_d == ST_FAULT) begin
      duty_d = SAFE_DUTY;
      dupd_d = 1'b1;
    end

    if (tick && !tick_slot(state_q) && ovr_q != '1) begin
      ovr_d = ovr_q + 1'b1;
    end
  end

  // Datapath and divider registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      tmo_q     <= '0;
      calc_q    <= '0;
      pot_q     <= '0;
      yk_q      <= '0;
      pending_q <= '0;
      duty_q    <= '0;
      dupd_q    <= 1'b0;
      ovr_q     <= '0;
    end else begin
      div_q     <= div_d;
      tmo_q     <= tmo_d;
      calc_q    <= calc_d;
      pot_q     <= pot_d;
      yk_q      <= yk_d;
      pending_q <= pending_d;
      duty_q    <= duty_d;
      dupd_q    <= dupd_d;
      ovr_q     <= ovr_d;
    end
  end

  // FSM outputs; strobes are suppressed in a cycle where enable has dropped.
  always_comb begin
    adc_start   = enable && (state_q == ST_ADC_REQ);
    ctrl_en     = enable && (state_q == ST_CALC) && (calc_q == '0);
    busy        = !tick_slot(state_q);
    fault       = (state_q == ST_FAULT);
    pot_latched = pot_q;
    duty_out    = duty_q;
    duty_update = dupd_q;
    overrun_cnt = ovr_q;
  end

endmodule
